// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter.
// Holds the read-response state encoding and the port-select constants.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2
  } resp_state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating starvation counter for the low-priority port.
// Counts cycles port B lost to port A; sat flags the forced-grant condition.
module starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic sat
);

  localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a synchronous data memory: pipeline port A has
// priority, debug/loader port B gets a forced grant after STARVE_MAX losses.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [7:0]    a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [7:0]    b_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [7:0]    m_wdata,
  input  logic [7:0]    m_rdata,
  output logic          stall
);

  resp_state_e state_q, state_d;
  logic        force_b;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        port_sel;

  assign cnt_clr = b_gnt || !b_req;
  assign cnt_inc = b_req && a_gnt;

  starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .sat (force_b)
  );

  // A saturated count only preempts A while B is actually asking.
  always_comb begin
    a_gnt    = a_req && !(force_b && b_req);
    b_gnt    = b_req && (!a_req || force_b);
    stall    = a_req && !a_gnt;
    port_sel = b_gnt ? PORT_B : PORT_A;
    m_en     = a_gnt || b_gnt;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = 8'h00;
    if (m_en) begin
      if (port_sel == PORT_B) begin
        m_we    = b_we;
        m_addr  = b_addr;
        m_wdata = b_wdata;
      end else begin
        m_we    = a_we;
        m_addr  = a_addr;
        m_wdata = a_wdata;
      end
    end
  end

  always_comb begin
    state_d = IDLE;
    if (a_gnt && !a_we) begin
      state_d = RD_A;
    end else if (b_gnt && !b_we) begin
      state_d = RD_B;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    a_rvalid = (state_q == RD_A);
    b_rvalid = (state_q == RD_B);
    a_rdata  = a_rvalid ? m_rdata : 8'h00;
    b_rdata  = b_rvalid ? m_rdata : 8'h00;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked by a per-cycle reference model.
module tb_dmem_arbiter;

  localparam int SMAX = 4;
  localparam int AW   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [AW-1:0] a_addr = 0, b_addr = 0;
  logic [7:0]    a_wdata = 0, b_wdata = 0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid, m_en, m_we, stall;
  logic [7:0]    a_rdata, b_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_rdata = 8'h00;

  int tests = 0;
  int fails = 0;

  logic [7:0] tb_mem    [0:255];
  logic [7:0] model_mem [0:255];

  dmem_arbiter #(.STARVE_MAX(SMAX), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .stall(stall)
  );

  always #5 clk = ~clk;

  // Synchronous memory seen by the arbiter's command port.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) tb_mem[m_addr] <= m_wdata;
      else      m_rdata <= tb_mem[m_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: starvation count, pending read and memory contents.
  int         m_scnt = 0;
  logic       pend_a = 0, pend_b = 0;
  logic [7:0] pend_data = 0;

  always @(negedge clk) begin
    logic forced, eag, ebg, eme, emwe;
    logic [AW-1:0] emaddr;
    logic [7:0] emwdata;
    if (rst) begin
      check("rst_a_rvalid", a_rvalid, 0);
      check("rst_b_rvalid", b_rvalid, 0);
      check("rst_rdata", {a_rdata, b_rdata}, 0);
      m_scnt = 0;
      pend_a = 0;
      pend_b = 0;
    end else begin
      forced = (m_scnt == SMAX) && b_req;
      eag    = a_req && !forced;
      ebg    = b_req && !eag;
      eme    = eag || ebg;
      emwe   = eag ? a_we : (ebg ? b_we : 1'b0);
      emaddr = eag ? a_addr : (ebg ? b_addr : '0);
      emwdata = eag ? a_wdata : (ebg ? b_wdata : 8'h00);
      check("a_gnt", a_gnt, eag);
      check("b_gnt", b_gnt, ebg);
      check("stall", stall, a_req && !eag);
      check("m_en", m_en, eme);
      check("m_we", m_we, emwe);
      check("m_addr", m_addr, emaddr);
      check("m_wdata", m_wdata, emwdata);
      check("a_rvalid", a_rvalid, pend_a);
      check("b_rvalid", b_rvalid, pend_b);
      check("a_rdata", a_rdata, pend_a ? pend_data : 8'h00);
      check("b_rdata", b_rdata, pend_b ? pend_data : 8'h00);
      // Advance the model to the state after the coming rising edge.
      if (ebg || !b_req)                 m_scnt = 0;
      else if (eag && m_scnt < SMAX)     m_scnt++;
      pend_a = eag && !a_we;
      pend_b = ebg && !b_we;
      if (pend_a)      pend_data = model_mem[a_addr];
      else if (pend_b) pend_data = model_mem[b_addr];
      if (eme && emwe) model_mem[emaddr] = emwdata;
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]    = 8'($urandom);
      model_mem[i] = tb_mem[i];
    end
    tb_mem[8'h10] = 8'h5A; model_mem[8'h10] = 8'h5A;
    tb_mem[8'h01] = 8'h11; model_mem[8'h01] = 8'h11;
    tb_mem[8'h02] = 8'h22; model_mem[8'h02] = 8'h22;

    #2;
    check("reset_a_rvalid", a_rvalid, 0);
    check("reset_m_en", m_en, 0);
    tick(); tick();
    rst = 1'b0;

    // Single A read of 0x10.
    tick();
    a_req = 1; a_we = 0; a_addr = 8'h10;
    #1;
    check("t31_a_gnt", a_gnt, 1);
    check("t31_stall", stall, 0);
    tick();
    a_req = 0;
    #1;
    check("t31_a_rvalid", a_rvalid, 1);
    check("t31_a_rdata", a_rdata, 8'h5A);

    // Single B write of 0xC3 to 0x00.
    tick();
    b_req = 1; b_we = 1; b_addr = 8'h00; b_wdata = 8'hC3;
    #1;
    check("t32_b_gnt", b_gnt, 1);
    check("t32_m_we", m_we, 1);
    check("t32_m_wdata", m_wdata, 8'hC3);
    tick();
    b_req = 0; b_we = 0;
    #1;
    check("t32_no_rvalid", {a_rvalid, b_rvalid}, 0);
    check("t32_mem", tb_mem[0], 8'hC3);

    // Both ports held: A,A,A,A,B repeating.
    tick();
    a_req = 1; a_addr = 8'h20; b_req = 1; b_addr = 8'h30;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t33_b_gnt", b_gnt, (i % 5) == 4);
      check("t33_stall", stall, (i % 5) == 4);
      tick();
    end
    a_req = 0; b_req = 0;

    // Alternating A then B reads.
    tick();
    a_req = 1; a_addr = 8'h01;
    tick();
    a_req = 0; b_req = 1; b_addr = 8'h02;
    #1;
    check("t34_a_rvalid", a_rvalid, 1);
    check("t34_a_rdata", a_rdata, 8'h11);
    check("t34_b_rvalid0", b_rvalid, 0);
    tick();
    b_req = 0;
    #1;
    check("t34_b_rvalid", b_rvalid, 1);
    check("t34_b_rdata", b_rdata, 8'h22);
    check("t34_a_rvalid0", a_rvalid, 0);

    // B drops at count 3: no forced grant afterwards.
    tick();
    a_req = 1; b_req = 1; a_addr = 8'h40; b_addr = 8'h41;
    for (int i = 0; i < 3; i++) begin
      #1; check("t36_pre_a_gnt", a_gnt, 1);
      tick();
    end
    b_req = 0;
    #1;
    check("t36_drop_a_gnt", a_gnt, 1);
    check("t36_drop_stall", stall, 0);
    tick();
    b_req = 1;
    for (int i = 0; i < 5; i++) begin
      #1; check("t36_post_b_gnt", b_gnt, i == 4);
      tick();
    end
    a_req = 0; b_req = 0;

    // Reset during an in-flight A read.
    tick();
    a_req = 1; a_addr = 8'h10;
    tick();
    a_req = 0; rst = 1;
    #1;
    check("t35_async_rvalid", a_rvalid, 0);
    tick(); tick();
    rst = 0;
    tick();
    #1;
    check("t35_after_rvalid", a_rvalid, 0);

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      tick();
      a_req   = ($urandom_range(0, 3) != 0);
      a_we    = $urandom_range(0, 1) == 1;
      a_addr  = 8'($urandom);
      a_wdata = 8'($urandom);
      b_req   = $urandom_range(0, 1) == 1;
      b_we    = $urandom_range(0, 1) == 1;
      b_addr  = 8'($urandom);
      b_wdata = 8'($urandom);
    end
    tick();
    a_req = 0; b_req = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive cycles port B may lose to port A before forced B grant.
REQ-002 Parameter AW, default 8: address width; data width fixed at 8.
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock, all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 a_req / a_we  in  1 each  pipeline MEM-stage request / write-enable.
REQ-007 a_addr  in  AW; a_wdata  in  8  pipeline address / store data.
REQ-008 a_gnt  out  1  pipeline request accepted this cycle.
REQ-009 a_rvalid  out  1; a_rdata  out  8  pipeline read response.
REQ-010 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: debug/loader port, same widths and meanings as port A.
REQ-011 m_en, m_we  out  1; m_addr  out  AW; m_wdata  out  8  synchronous data-memory command.
REQ-012 m_rdata  in  8  memory read data, valid one cycle after m_en && !m_we.
REQ-013 stall  out  1  to hazard unit: high when a_req && !a_gnt.

Function
REQ-014 One memory access SHALL be issued per cycle; m_en = a_gnt | b_gnt, command fields muxed from the granted port in the same cycle.
REQ-015 Default priority SHALL be port A; b_gnt = b_req && (!a_req || force_b).
REQ-016 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment when b_req && a_gnt, clear when b_gnt or !b_req, and saturate at STARVE_MAX.
REQ-017 force_b SHALL equal (starve_cnt == STARVE_MAX); under force_b, a_gnt=0 and stall=1 for exactly that cycle.
REQ-018 Response FSM states IDLE, RD_A, RD_B: next state RD_A on a_gnt&&!a_we, RD_B on b_gnt&&!b_we, else IDLE; evaluated every cycle.
REQ-019 In RD_A, a_rvalid=1 and a_rdata=m_rdata; in RD_B, b_rvalid=1 and b_rdata=m_rdata; otherwise rvalid=0, rdata=8'h00.
REQ-020 Read latency SHALL be exactly 1 cycle from grant to rvalid; back-to-back reads from either port SHALL sustain 1 access per cycle.
REQ-021 Writes SHALL complete on the grant cycle and produce no rvalid.
REQ-022 Ungranted requesters SHALL hold req/addr/data stable; arbiter keeps no request queue.
REQ-023 Simultaneous a_req and b_req with starve_cnt<STARVE_MAX SHALL grant A only and increment starve_cnt.
REQ-024 a_req with b_req low SHALL never stall.
REQ-025 No grant SHALL drive m_en=0, m_we=0, m_addr=0, m_wdata=0.

Reset
REQ-026 On rst: FSM=IDLE, starve_cnt=0; a_rvalid, b_rvalid, rdata outputs=0 immediately (asynchronous).
REQ-027 Reset during an in-flight read SHALL drop the response; no rvalid is produced for it after reset release.
REQ-028 Grant and memory-command outputs are combinational from requests and state; first grant possible the first edge after rst deasserts.

Structure
REQ-029 Shared package SHALL hold the response-state enum (IDLE, RD_A, RD_B) and port-select constants PORT_A=0, PORT_B=1.
REQ-030 Sub-module starve_counter (saturating counter with clear/inc/sat_flag) is natural; all other logic is flat.

Verification
REQ-031 Only a_req read addr 0x10, mem[0x10]=0x5A -> a_gnt same cycle, a_rvalid=1 with a_rdata=0x5A next cycle, stall=0.
REQ-032 Only b_req write addr 0x00 data 0xC3 -> b_gnt=1, m_we=1, m_wdata=0xC3; no rvalid on either port; mem[0x00]=0xC3.
REQ-033 a_req and b_req held high continuously, STARVE_MAX=4 -> grants A,A,A,A,B repeating; stall=1 on every B cycle.
REQ-034 Alternating reads A(0x01) then B(0x02), mem=0x11/0x22 -> a_rvalid/0x11 then b_rvalid/0x22 on consecutive cycles, no crossover.
REQ-035 rst asserted the cycle after A read grant -> a_rvalid stays 0, starve_cnt=0, FSM=IDLE after release.
REQ-036 b_req dropped while starve_cnt=3 -> starve_cnt clears to 0; A resumes priority with no forced B grant.
